mips_prog_loader: RTL and testbench

Writes a program image into the mips32 instruction/data memory from a byte stream, then releases the processor. The processor's instruction fetch reads Mem starting at PC; this block fills Mem from address 0 and holds HALTED until the image is complete. When the image is loaded it clears HALTED and pulses a PC load to address 0. It sits between a host byte source (UART receiver or bench) and the mips32 memory write port, in the clk1 domain.

---
 rtl/mips_prog_loader_if.sv | 22 ++
 rtl/mips_prog_loader.sv | 135 +++++++++++++
 tb/tb_mips_prog_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_prog_loader_if.sv
// Byte-stream handshake between a host source and the program loader.
// A byte transfers on any clk1 edge where in_valid and in_ready are both high.
interface mips_prog_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       in_last;

    modport master (
        output in_valid,
        output in_byte,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_byte,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/mips_prog_loader.sv
// Loads a big-endian byte image into mips32 Mem from word 0, then
// releases the processor with a PC load to START_PC.
module mips_prog_loader #(
    parameter int          ADDR_W     = 10,
    parameter int          APPEND_HLT = 1,
    parameter logic [31:0] START_PC   = 32'h0
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    mips_prog_loader_if.slave src,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_halt,
    output logic              pc_load,
    output logic [31:0]       pc_value,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_overflow
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOAD    = 2'd1;
    localparam logic [1:0] HLT_WR  = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    localparam logic [31:0] HLT_WORD = 32'hfc000000;

    logic [1:0]  state;
    logic [1:0]  idx;
    logic [31:0] acc;
    logic        last_seen;
    logic        full;
    logic        accept;
    logic [31:0] word_nxt;

    // Top bit of word_count set means every Mem word has been written.
    assign full     = word_count[ADDR_W];
    assign src.in_ready = (state == LOAD) && !last_seen;
    assign accept   = src.in_ready && src.in_valid;
    assign pc_value = START_PC;

    // Drop the incoming byte into its lane; lower lanes stay zero.
    always_comb begin
        word_nxt = acc | ({src.in_byte, 24'h0} >> {idx, 3'b000});
    end

    // Load sequencing, word writes and processor release.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= 2'd0;
            acc          <= 32'h0;
            last_seen    <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'h0;
            cpu_halt     <= 1'b1;
            pc_load      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            word_count   <= '0;
            err_overflow <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            pc_load <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= LOAD;
                        busy         <= 1'b1;
                        cpu_halt     <= 1'b1;
                        word_count   <= '0;
                        idx          <= 2'd0;
                        acc          <= 32'h0;
                        last_seen    <= 1'b0;
                        err_overflow <= 1'b0;
                    end
                end
                LOAD: begin
                    if (last_seen) begin
                        // Final data word has had its write cycle.
                        if ((APPEND_HLT != 0) && !full) begin
                            state     <= HLT_WR;
                            mem_we    <= 1'b1;
                            mem_addr  <= word_count[ADDR_W-1:0];
                            mem_wdata <= HLT_WORD;
                        end else begin
                            state    <= RELEASE;
                            pc_load  <= 1'b1;
                            done     <= 1'b1;
                            cpu_halt <= 1'b0;
                        end
                    end else if (accept) begin
                        if (src.in_last) begin
                            last_seen <= 1'b1;
                        end
                        if (full) begin
                            if (!src.in_last) begin
                                err_overflow <= 1'b1;
                            end
                        end else if ((idx == 2'd3) || src.in_last) begin
                            mem_we     <= 1'b1;
                            mem_addr   <= word_count[ADDR_W-1:0];
                            mem_wdata  <= word_nxt;
                            word_count <= word_count + (ADDR_W+1)'(1);
                            acc        <= 32'h0;
                            idx        <= 2'd0;
                        end else begin
                            acc <= word_nxt;
                            idx <= idx + 2'd1;
                        end
                    end
                end
                HLT_WR: begin
                    state    <= RELEASE;
                    pc_load  <= 1'b1;
                    done     <= 1'b1;
                    cpu_halt <= 1'b0;
                end
                RELEASE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for mips_prog_loader: a full-size loader and a
// four-word loader share one byte driver selected by sel.
module tb_mips_prog_loader;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       vld = 1'b0;
    logic       lst = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] byt = 8'h0;

    int checks = 0;
    int failures = 0;
    int npl_a = 0;
    int npl_b = 0;

    logic [63:0] qa[$];
    logic [63:0] qb[$];
    logic [63:0] ea;
    logic [63:0] eb;

    logic        we_a, halt_a, pl_a, busy_a, done_a, err_a;
    logic [9:0]  addr_a;
    logic [31:0] wd_a, pc_a;
    logic [10:0] wc_a;

    logic        we_b, halt_b, pl_b, busy_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wd_b, pc_b;
    logic [2:0]  wc_b;

    mips_prog_loader_if ia ();
    mips_prog_loader_if ib ();

    assign ia.in_valid = vld & ~sel;
    assign ia.in_byte  = byt;
    assign ia.in_last  = lst;
    assign ib.in_valid = vld & sel;
    assign ib.in_byte  = byt;
    assign ib.in_last  = lst;

    mips_prog_loader #(.ADDR_W(10)) dut_a (
        .clk1(clk), .rst(rst), .start(start & ~sel), .src(ia),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
        .cpu_halt(halt_a), .pc_load(pl_a), .pc_value(pc_a),
        .busy(busy_a), .done(done_a), .word_count(wc_a),
        .err_overflow(err_a)
    );

    mips_prog_loader #(.ADDR_W(2)) dut_b (
        .clk1(clk), .rst(rst), .start(start & sel), .src(ib),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
        .cpu_halt(halt_b), .pc_load(pl_b), .pc_value(pc_b),
        .busy(busy_b), .done(done_b), .word_count(wc_b),
        .err_overflow(err_b)
    );

    always #5 clk = ~clk;

    logic        rdy_s, done_s, busy_s, halt_s, err_s, pl_s;
    logic [31:0] pc_s;
    logic [10:0] wc_s;
    assign rdy_s  = sel ? ib.in_ready : ia.in_ready;
    assign done_s = sel ? done_b : done_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign halt_s = sel ? halt_b : halt_a;
    assign err_s  = sel ? err_b : err_a;
    assign pl_s   = sel ? pl_b : pl_a;
    assign pc_s   = sel ? pc_b : pc_a;
    assign wc_s   = sel ? 11'(wc_b) : wc_a;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write monitors: every strobe must match the next expected write.
    always @(negedge clk) begin
        if (pl_a) npl_a++;
        if (we_a) begin
            check("wr_a_pending", 64'(qa.size() != 0), 64'd1);
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                check("wr_a", {22'h0, addr_a, wd_a}, ea);
            end
        end
    end

    always @(negedge clk) begin
        if (pl_b) npl_b++;
        if (we_b) begin
            check("wr_b_pending", 64'(qb.size() != 0), 64'd1);
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                check("wr_b", {30'h0, addr_b, wd_b}, eb);
            end
        end
    end

    // Reference model: big-endian words, zero pad, capacity, HLT append.
    task automatic expect_image(input bit s, input bq_t bs,
                                output int cnt, output bit err);
        int cap = s ? 4 : 1024;
        int n = bs.size();
        int nw = (n + 3) / 4;
        logic [31:0] w;
        logic [63:0] e;
        cnt = 0;
        for (int i = 0; i < nw; i++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++)
                if (4 * i + j < n) w[31-8*j -: 8] = bs[4*i+j];
            if (i < cap) begin
                e = {32'(i), w};
                if (s) qb.push_back(e); else qa.push_back(e);
                cnt++;
            end
        end
        if (cnt < cap) begin
            e = {32'(cnt), 32'hfc000000};
            if (s) qb.push_back(e); else qa.push_back(e);
        end
        err = (n >= 4 * cap + 2);
    endtask

    task automatic push_byte(input logic [7:0] b, input bit last,
                             input bit st);
        int n = 0;
        @(negedge clk);
        vld = 1'b1; byt = b; lst = last; start = st;
        while (!rdy_s && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("rdy_timeout", 64'(rdy_s), 64'd1);
    endtask

    task automatic start_pulse(input bit junk);
        @(negedge clk);
        start = 1'b1;
        vld = junk; byt = 8'hee; lst = 1'b0;
        @(negedge clk);
        start = 1'b0; vld = 1'b0;
        check("busy_after_start", 64'(busy_s), 64'd1);
        check("halt_after_start", 64'(halt_s), 64'd1);
    endtask

    task automatic run_load(input bit s, input bq_t bs, input int st_at,
                            input bit junk);
        int cnt;
        bit err;
        int n = 0;
        int npl;
        sel = s;
        expect_image(s, bs, cnt, err);
        npl_a = 0; npl_b = 0;
        start_pulse(junk);
        for (int i = 0; i < bs.size(); i++)
            push_byte(bs[i], i == bs.size() - 1, i == st_at);
        @(negedge clk);
        vld = 1'b0; lst = 1'b0; start = 1'b0;
        check("rdy_after_last", 64'(rdy_s), 64'd0);
        while (!done_s && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(done_s), 64'd1);
        check("pl_with_done", 64'(pl_s), 64'd1);
        check("rdy_release", 64'(rdy_s), 64'd0);
        check("halt_release", 64'(halt_s), 64'd0);
        check("pc_value", 64'(pc_s), 64'h0);
        @(negedge clk);
        check("busy_dropped", 64'(busy_s), 64'd0);
        check("word_count", 64'(wc_s), 64'(cnt));
        check("err_overflow", 64'(err_s), 64'(err));
        npl = s ? npl_b : npl_a;
        check("pl_pulses", 64'(npl), 64'd1);
        check("writes_done", 64'(s ? qb.size() : qa.size()), 64'd0);
    endtask

    initial begin
        bq_t bs;
        logic [31:0] img [9];
        img = '{32'h4820000a, 32'h48400014, 32'h48600019, 32'h0ce73800,
                32'h00222000, 32'h0ce73800, 32'h0ce73800, 32'h00832800,
                32'hfc000000};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_halt", 64'(halt_a), 64'd1);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_rdy", 64'(ia.in_ready), 64'd0);
        check("rst_we", 64'(we_a), 64'd0);
        check("rst_addr", 64'(addr_a), 64'd0);
        check("rst_wdata", 64'(wd_a), 64'd0);
        check("rst_pl", 64'(pl_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_wc", 64'(wc_a), 64'd0);
        check("rst_err", 64'(err_a), 64'd0);
        check("rst_halt_b", 64'(halt_b), 64'd1);

        // Bytes offered in IDLE must be refused and write nothing.
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vld = 1'b1; byt = 8'h55;
            check("idle_rdy", 64'(ia.in_ready), 64'd0);
        end
        @(negedge clk);
        vld = 1'b0;

        // Nominal image, with a stray start mid-stream.
        bs = {};
        foreach (img[i])
            for (int j = 0; j < 4; j++) bs.push_back(img[i][31-8*j -: 8]);
        run_load(1'b0, bs, 10, 1'b0);

        // Partial final word; start coincides with a refused byte.
        bs = '{8'h48, 8'h20, 8'h00, 8'h0a, 8'hab, 8'hcd};
        run_load(1'b0, bs, -1, 1'b1);
        check("halt_reload_end", 64'(halt_a), 64'd0);

        // Single-byte image on a word boundary.
        bs = '{8'h7f};
        run_load(1'b0, bs, -1, 1'b0);

        // Overflow on the four-word loader.
        bs = {};
        for (int i = 0; i < 24; i++) bs.push_back(8'(8'h10 + i));
        run_load(1'b1, bs, -1, 1'b0);

        // Reset mid-load: only the first word reaches Mem.
        sel = 1'b0;
        qa.push_back({32'h0, 32'h01020304});
        start_pulse(1'b0);
        for (int i = 0; i < 6; i++) push_byte(8'(i + 1), 1'b0, 1'b0);
        @(negedge clk);
        vld = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_halt", 64'(halt_a), 64'd1);
        check("mid_rst_busy", 64'(busy_a), 64'd0);
        check("mid_rst_rdy", 64'(ia.in_ready), 64'd0);
        check("mid_rst_we", 64'(we_a), 64'd0);
        check("mid_rst_wc", 64'(wc_a), 64'd0);
        check("mid_rst_addr", 64'(addr_a), 64'd0);
        check("mid_rst_q", 64'(qa.size()), 64'd0);
        repeat (3) @(negedge clk);
        check("mid_rst_quiet", 64'(we_a), 64'd0);

        bs = '{8'hde, 8'had, 8'hbe, 8'hef};
        run_load(1'b0, bs, -1, 1'b0);

        repeat (3) @(negedge clk);
        check("no_extra_a", 64'(qa.size()), 64'd0);
        check("no_extra_b", 64'(qb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
